tmds_period_scheduler: RTL and testbench

- Per-pixel scheduler that sequences the HDMI period structure feeding the TMDS encoders and the 10:1 serializer.
- Decides every clk_pixel whether the link carries a control period, video preamble, video guard band, active video, data-island preamble, island guard band or island packet data. Hands out packet slots to the packet source via a valid/ready handshake.
- Also owns link bring-up: holds the serializer in reset for a fixed time after block reset.

---
 rtl/tmds_period_scheduler_if.sv | 25 ++
 rtl/tmds_period_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_tmds_period_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_period_scheduler_if.sv
// tmds_period_scheduler_if: timing, packet handshake and period outputs
// between the video timing/packet source and the TMDS period scheduler.
interface tmds_period_scheduler_if;
    logic        de;
    logic [11:0] cycles_to_active;
    logic        packet_valid;
    logic        packet_ready;
    logic        serializer_reset;
    logic [2:0]  mode;
    logic [3:0]  ctl;
    logic [4:0]  island_index;
    logic        sched_error;

    modport master (
        output de, cycles_to_active, packet_valid,
        input  packet_ready, serializer_reset, mode, ctl,
        input  island_index, sched_error
    );

    modport slave (
        input  de, cycles_to_active, packet_valid,
        output packet_ready, serializer_reset, mode, ctl,
        output island_index, sched_error
    );
endinterface

// File: rtl/tmds_period_scheduler.sv
// tmds_period_scheduler: per-pixel HDMI period sequencer. Picks control,
// preamble, guard, video or data-island periods and grants packet slots.
module tmds_period_scheduler #(
    parameter int RESET_HOLD   = 16,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int ISLAND_LEN   = 32,
    parameter int MIN_CONTROL  = 4,
    parameter int MAX_PACKETS  = 18,
    parameter int DVI_OUTPUT   = 0
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    tmds_period_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_CONTROL    = 3'd0,
        S_VID_PRE    = 3'd1,
        S_VID_GUARD  = 3'd2,
        S_VIDEO      = 3'd3,
        S_ISL_PRE    = 3'd4,
        S_ISL_GUARD  = 3'd5,
        S_ISL_DATA   = 3'd6,
        S_LINK_RESET = 3'd7
    } state_t;

    localparam logic [11:0] VPRE_LO  = 12'(GUARD_LEN + 1);
    localparam logic [11:0] VPRE_HI  = 12'(GUARD_LEN + PREAMBLE_LEN);
    localparam logic [11:0] GUARD_HI = 12'(GUARD_LEN);
    // Room for a full island plus the control/preamble/guard lead-in
    // that the following video period still needs.
    localparam logic [11:0] START_MIN = 12'(PREAMBLE_LEN + 2 * GUARD_LEN
        + ISLAND_LEN + MIN_CONTROL + PREAMBLE_LEN + GUARD_LEN);
    localparam logic [11:0] CONT_MIN = 12'(ISLAND_LEN + GUARD_LEN
        + MIN_CONTROL + PREAMBLE_LEN + GUARD_LEN);

    state_t      state_q, state_d, vid_next;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  ctrl_cnt_q, ctrl_cnt_d;
    logic [7:0]  phase_q, phase_d;
    logic [4:0]  index_q, index_d;
    logic        trailing_q, trailing_d;
    logic [5:0]  pkt_cnt_q, pkt_cnt_d;
    logic        ready_q, ready_d;
    logic        sres_q, sres_d;
    logic [2:0]  mode_q, mode_d;
    logic [3:0]  ctl_q, ctl_d;
    logic        err_q, err_d;
    logic        start_ok, cont_ok;
    logic [11:0] cta;

    assign cta = bus.cycles_to_active;
    assign start_ok = bus.packet_valid
        && (ctrl_cnt_q >= 4'(MIN_CONTROL)) && (cta >= START_MIN);
    assign cont_ok = bus.packet_valid
        && (pkt_cnt_q < 6'(MAX_PACKETS)) && (cta >= CONT_MIN);

    // State and counter registers with synchronous reset into link bring-up
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q    <= S_LINK_RESET;
            hold_q     <= '0;
            ctrl_cnt_q <= '0;
            phase_q    <= '0;
            index_q    <= '0;
            trailing_q <= 1'b0;
            pkt_cnt_q  <= '0;
            ready_q    <= 1'b0;
            sres_q     <= 1'b1;
            mode_q     <= '0;
            ctl_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            phase_q    <= phase_d;
            index_q    <= index_d;
            trailing_q <= trailing_d;
            pkt_cnt_q  <= pkt_cnt_d;
            ready_q    <= ready_d;
            sres_q     <= sres_d;
            mode_q     <= mode_d;
            ctl_q      <= ctl_d;
            err_q      <= err_d;
        end
    end

    // Period dictated by video timing alone
    always_comb begin
        vid_next = S_CONTROL;
        if (bus.de) begin
            vid_next = S_VIDEO;
        end else if (cta >= VPRE_LO && cta <= VPRE_HI) begin
            vid_next = S_VID_PRE;
        end else if (cta >= 12'd1 && cta <= GUARD_HI) begin
            vid_next = S_VID_GUARD;
        end
    end

    // Next state, island sequencing and packet grants
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        phase_d    = phase_q;
        index_d    = index_q;
        trailing_d = trailing_q;
        pkt_cnt_d  = pkt_cnt_q;
        ready_d    = 1'b0;
        if (state_q == S_LINK_RESET) begin
            if (hold_q == 16'(RESET_HOLD - 1)) begin
                state_d = S_CONTROL;
            end else begin
                hold_d = hold_q + 16'd1;
            end
        end else if (DVI_OUTPUT != 0) begin
            state_d = bus.de ? S_VIDEO : S_CONTROL;
        end else if (bus.de) begin
            state_d = S_VIDEO;
        end else begin
            case (state_q)
                S_ISL_PRE: begin
                    if (phase_q == 8'(PREAMBLE_LEN - 1)) begin
                        state_d    = S_ISL_GUARD;
                        phase_d    = '0;
                        trailing_d = 1'b0;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                S_ISL_GUARD: begin
                    if (phase_q == 8'(GUARD_LEN - 1)) begin
                        phase_d = '0;
                        state_d = trailing_q ? vid_next : S_ISL_DATA;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                S_ISL_DATA: begin
                    if (index_q == 5'(ISLAND_LEN - 1)) begin
                        // ready_q here marks a packet granted on this pixel
                        if (!ready_q) begin
                            state_d    = S_ISL_GUARD;
                            phase_d    = '0;
                            trailing_d = 1'b1;
                        end
                        index_d = '0;
                    end else begin
                        index_d = index_q + 5'd1;
                        if (index_q == 5'(ISLAND_LEN - 2) && cont_ok) begin
                            ready_d   = 1'b1;
                            pkt_cnt_d = pkt_cnt_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_d = vid_next;
                    if (state_q == S_CONTROL && vid_next == S_CONTROL
                        && start_ok) begin
                        state_d   = S_ISL_PRE;
                        phase_d   = '0;
                        ready_d   = 1'b1;
                        pkt_cnt_d = 6'd1;
                    end
                end
            endcase
        end
        if (state_d != S_ISL_DATA) begin
            index_d = '0;
        end
        ctrl_cnt_d = '0;
        if (state_d == S_CONTROL) begin
            ctrl_cnt_d = (ctrl_cnt_q == 4'hf) ? 4'hf : ctrl_cnt_q + 4'd1;
        end
    end

    // Registered link outputs derived from the next state
    always_comb begin
        sres_d = (state_d == S_LINK_RESET);
        mode_d = sres_d ? 3'd0 : 3'(state_d);
        ctl_d  = 4'b0000;
        if (state_d == S_VID_PRE) begin
            ctl_d = 4'b0001;
        end else if (state_d == S_ISL_PRE) begin
            ctl_d = 4'b0101;
        end
        err_d = err_q;
        if (DVI_OUTPUT == 0 && state_d == S_VIDEO && state_q != S_VIDEO
            && state_q != S_VID_GUARD && state_q != S_LINK_RESET) begin
            err_d = 1'b1;
        end
    end

    assign bus.packet_ready     = ready_q;
    assign bus.serializer_reset = sres_q;
    assign bus.mode             = mode_q;
    assign bus.ctl              = ctl_q;
    assign bus.island_index     = index_q;
    assign bus.sched_error      = err_q;
endmodule

// File: tb/tb_tmds_period_scheduler.sv
// tb_tmds_period_scheduler: vector table, directed island sequences and a
// randomized frame run against a pixel-plan reference model.
module tb_tmds_period_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        de;
    logic [11:0] cta;
    logic        pv;
    int          total = 0;
    int          bad = 0;

    tmds_period_scheduler_if hs();
    tmds_period_scheduler_if ds();

    assign hs.de = de;
    assign hs.cycles_to_active = cta;
    assign hs.packet_valid = pv;
    assign ds.de = de;
    assign ds.cycles_to_active = cta;
    assign ds.packet_valid = pv;

    tmds_period_scheduler #(.DVI_OUTPUT(0)) u_hdmi (
        .clk_pixel(clk),
        .reset(reset),
        .bus(hs)
    );

    tmds_period_scheduler #(.DVI_OUTPUT(1)) u_dvi (
        .clk_pixel(clk),
        .reset(reset),
        .bus(ds)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        de = 1'b0;
        cta = 12'hfff;
        pv = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [3:0] ctl_of(input logic [2:0] m);
        if (m == 3'd1) return 4'b0001;
        if (m == 3'd4) return 4'b0101;
        return 4'b0000;
    endfunction

    // {mode, index} of pixel k of a single island, k=0 is the first preamble
    function automatic logic [7:0] isl_exp(input int k);
        if (k < 8) return {3'd4, 5'd0};
        if (k < 10) return {3'd5, 5'd0};
        if (k < 42) return {3'd6, 5'(k - 10)};
        if (k < 44) return {3'd5, 5'd0};
        return {3'd0, 5'd0};
    endfunction

    task automatic bring_up(input string tag);
        int n;
        int mbad;
        reset = 1'b1;
        de = 1'b0;
        cta = 12'hfff;
        pv = 1'b0;
        repeat (3) tick();
        chk({tag, "_sres"}, hs.serializer_reset, 1);
        chk({tag, "_mode"}, hs.mode, 0);
        chk({tag, "_ready"}, hs.packet_ready, 0);
        chk({tag, "_ctl"}, hs.ctl, 0);
        chk({tag, "_idx"}, hs.island_index, 0);
        chk({tag, "_err"}, hs.sched_error, 0);
        reset = 1'b0;
        n = 0;
        mbad = 0;
        while (hs.serializer_reset === 1'b1 && n < 64) begin
            if (hs.mode !== 3'd0) mbad++;
            n++;
            tick();
        end
        chk({tag, "_hold_cycles"}, n, 16);
        chk({tag, "_hold_mode"}, mbad, 0);
        chk({tag, "_ctrl_mode"}, hs.mode, 0);
        chk({tag, "_dvi_sres"}, ds.serializer_reset, 0);
    endtask

    // Reference model: islands are planned as a queue of future pixels
    typedef struct packed {
        logic [2:0] mode;
        logic [4:0] idx;
        logic       rdy;
    } pix_t;

    pix_t plan[$];
    int   m_prev;
    int   m_run;
    int   m_npk;
    bit   m_err;

    function automatic int vrule(input int c);
        if (c >= 3 && c <= 10) return 1;
        if (c >= 1 && c <= 2) return 2;
        return 0;
    endfunction

    task automatic model_step(input logic d, input int c, input logic p,
                              output pix_t e);
        e = '{3'd0, 5'd0, 1'b0};
        if (d) begin
            plan.delete();
            e.mode = 3'd3;
            if (m_prev != 2 && m_prev != 3) m_err = 1'b1;
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
            if (e.mode == 3'd6 && e.idx == 5'd31 && p && m_npk < 18
                && c >= 48) begin
                e.rdy = 1'b1;
                m_npk++;
                for (int i = 31; i >= 0; i--)
                    plan.push_front('{3'd6, 5'(i), 1'b0});
            end
        end else begin
            e.mode = 3'(vrule(c));
            if (e.mode == 3'd0 && m_prev == 0 && m_run >= 4 && p
                && c >= 58) begin
                e = '{3'd4, 5'd0, 1'b1};
                m_npk = 1;
                for (int i = 0; i < 7; i++)
                    plan.push_back('{3'd4, 5'd0, 1'b0});
                for (int i = 0; i < 2; i++)
                    plan.push_back('{3'd5, 5'd0, 1'b0});
                for (int i = 0; i < 32; i++)
                    plan.push_back('{3'd6, 5'(i), 1'b0});
                for (int i = 0; i < 2; i++)
                    plan.push_back('{3'd5, 5'd0, 1'b0});
            end
        end
        m_run = (e.mode == 3'd0) ? m_run + 1 : 0;
        m_prev = int'(e.mode);
    endtask

    typedef struct {
        logic        de;
        logic [11:0] cta;
        logic [2:0]  e_mode;
        logic [3:0]  e_ctl;
        logic [2:0]  e_dvi;
    } vec_t;

    initial begin
        vec_t vt[25];
        pix_t e;
        int   rc;
        int   isl;
        int   dpx;
        int   idx2;
        int   sbad;
        int   dbad;
        int   cbad;
        int   mm_mode;
        int   mm_ctl;
        int   mm_idx;
        int   mm_rdy;
        int   mm_err;
        int   mm_dvi;
        int   blank_left;
        int   act_left;
        logic [7:0] x;

        for (int i = 0; i < 25; i++) begin
            vt[i].de = (i >= 20 && i <= 22);
            vt[i].cta = (i < 20) ? 12'(20 - i) : (i <= 22 ? 12'd0 : 12'hfff);
            if (i < 10) vt[i].e_mode = 3'd0;
            else if (i < 18) vt[i].e_mode = 3'd1;
            else if (i < 20) vt[i].e_mode = 3'd2;
            else if (i <= 22) vt[i].e_mode = 3'd3;
            else vt[i].e_mode = 3'd0;
            vt[i].e_ctl = ctl_of(vt[i].e_mode);
            vt[i].e_dvi = vt[i].de ? 3'd3 : 3'd0;
        end

        reset = 1'b1;
        de = 1'b0;
        cta = 12'hfff;
        pv = 1'b0;
        bring_up("rst1");
        idle(6);

        for (int i = 0; i < 25; i++) begin
            de = vt[i].de;
            cta = vt[i].cta;
            pv = 1'b0;
            tick();
            chk($sformatf("vec%0d_mode", i), hs.mode, vt[i].e_mode);
            chk($sformatf("vec%0d_ctl", i), hs.ctl, vt[i].e_ctl);
            chk($sformatf("vec%0d_err", i), hs.sched_error, 0);
            chk($sformatf("vec%0d_dvi", i), ds.mode, vt[i].e_dvi);
        end

        idle(6);
        pv = 1'b1;
        cta = 12'd200;
        rc = 0;
        sbad = 0;
        dbad = 0;
        for (int k = 0; k < 46; k++) begin
            tick();
            if (k == 0) chk("isl_first_ready", hs.packet_ready, 1);
            if (hs.packet_ready === 1'b1) rc++;
            x = isl_exp(k);
            if (hs.mode !== x[7:5] || hs.island_index !== x[4:0]
                || hs.ctl !== ctl_of(x[7:5])) sbad++;
            if (ds.packet_ready !== 1'b0 || ds.mode !== 3'd0
                || ds.ctl !== 4'd0) dbad++;
            pv = 1'b0;
            cta = cta - 12'd1;
        end
        chk("isl_ready_count", rc, 1);
        chk("isl_sequence", sbad, 0);
        chk("isl_dvi", dbad, 0);

        idle(6);
        pv = 1'b1;
        cta = 12'd100;
        rc = 0;
        dpx = 0;
        idx2 = 99;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (k == 0) chk("b2b_start_ready", hs.packet_ready, 1);
            if (hs.packet_ready === 1'b1) begin
                rc++;
                if (rc == 2) idx2 = int'(hs.island_index);
            end
            if (hs.mode === 3'd6) dpx++;
            cta = cta - 12'd1;
        end
        chk("b2b_ready_count", rc, 2);
        chk("b2b_second_idx", idx2, 31);
        chk("b2b_data_pixels", dpx, 64);
        chk("b2b_end_mode", hs.mode, 0);

        idle(6);
        pv = 1'b1;
        cta = 12'd57;
        rc = 0;
        isl = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (hs.packet_ready === 1'b1) rc++;
            if (hs.mode === 3'd4) isl++;
            cta = cta - 12'd1;
        end
        chk("m57_ready", rc, 0);
        chk("m57_isl_pre", isl, 0);

        idle(6);
        pv = 1'b1;
        cta = 12'd58;
        tick();
        chk("m58_ready", hs.packet_ready, 1);
        chk("m58_mode", hs.mode, 4);
        pv = 1'b0;
        for (int k = 1; k < 46; k++) begin
            cta = cta - 12'd1;
            tick();
        end
        chk("m58_end_mode", hs.mode, 0);

        idle(6);
        cta = 12'd1;
        tick();
        de = 1'b1;
        cta = 12'd0;
        tick();
        chk("vg_video_mode", hs.mode, 3);
        chk("vg_video_err", hs.sched_error, 0);
        de = 1'b0;
        cta = 12'hfff;
        pv = 1'b1;
        cbad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (hs.mode !== 3'd0) cbad++;
        end
        chk("minctl_control_run", cbad, 0);
        tick();
        chk("minctl_isl_pre", hs.mode, 4);
        chk("minctl_ready", hs.packet_ready, 1);
        pv = 1'b0;
        repeat (14) tick();
        chk("viol_pre_mode", hs.mode, 6);
        chk("viol_pre_idx", hs.island_index, 4);
        de = 1'b1;
        cta = 12'd0;
        tick();
        chk("viol_mode", hs.mode, 3);
        chk("viol_err", hs.sched_error, 1);
        chk("viol_ready", hs.packet_ready, 0);
        chk("viol_idx", hs.island_index, 0);
        chk("viol_dvi_mode", ds.mode, 3);
        chk("viol_dvi_err", ds.sched_error, 0);
        de = 1'b0;
        cta = 12'hfff;
        repeat (5) tick();
        chk("err_sticky", hs.sched_error, 1);
        chk("err_sticky_mode", hs.mode, 0);

        bring_up("rst2");
        idle(20);

        plan.delete();
        m_prev = 0;
        m_run = 15;
        m_npk = 0;
        m_err = 1'b0;
        mm_mode = 0;
        mm_ctl = 0;
        mm_idx = 0;
        mm_rdy = 0;
        mm_err = 0;
        mm_dvi = 0;
        blank_left = int'($urandom_range(1, 400));
        act_left = 0;
        for (int c = 0; c < 6000; c++) begin
            if (blank_left > 0) begin
                de = 1'b0;
                cta = (blank_left > 4095) ? 12'hfff : 12'(blank_left);
                blank_left--;
                if (blank_left == 0) act_left = int'($urandom_range(1, 40));
            end else begin
                de = 1'b1;
                cta = 12'd0;
                act_left--;
                if (act_left == 0) begin
                    if (c < 3000) blank_left = int'($urandom_range(1, 400));
                    else blank_left = int'($urandom_range(1, 900));
                end
            end
            pv = (c >= 3000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            model_step(de, int'(cta), pv, e);
            tick();
            if (hs.mode !== e.mode) begin
                if (mm_mode == 0)
                    $display("rand cycle %0d mode %0d want %0d",
                             c, hs.mode, e.mode);
                mm_mode++;
            end
            if (hs.ctl !== ctl_of(e.mode)) mm_ctl++;
            if (hs.island_index !== e.idx) mm_idx++;
            if (hs.packet_ready !== e.rdy) mm_rdy++;
            if (hs.sched_error !== m_err) mm_err++;
            if (ds.mode !== (de ? 3'd3 : 3'd0) || ds.ctl !== 4'd0
                || ds.packet_ready !== 1'b0 || ds.sched_error !== 1'b0)
                mm_dvi++;
        end
        chk("rand_mode", mm_mode, 0);
        chk("rand_ctl", mm_ctl, 0);
        chk("rand_idx", mm_idx, 0);
        chk("rand_ready", mm_rdy, 0);
        chk("rand_err", mm_err, 0);
        chk("rand_dvi", mm_dvi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
